// File: rtl/bp_be_pkg.sv
// bp_be_pkg: shared pointer-width macro and count-bound helper for the BE issue queue
`define BP_BE_IQ_PTR_WIDTH(els_p) ($clog2(els_p)+1)

package bp_be_pkg;

  function automatic bit cnt_ok(int cnt, int bound);
    return cnt <= bound;
  endfunction

endpackage

// File: rtl/bp_be_iq_mem.sv
// bp_be_iq_mem: register file, one sync write port, issue_width_p wrap-aware async read ports
module bp_be_iq_mem #(
    parameter int width_p       = 64,
    parameter int els_p         = 8,
    parameter int issue_width_p = 2
) (
    input  logic                             clk_i,
    input  logic                             w_v_i,
    input  logic [$clog2(els_p)-1:0]         w_addr_i,
    input  logic [width_p-1:0]               w_data_i,
    input  logic [$clog2(els_p)-1:0]         r_addr_i,
    output logic [issue_width_p*width_p-1:0] r_data_o
);
    localparam int aw = $clog2(els_p);

    logic [width_p-1:0] mem [els_p];

    always_ff @(posedge clk_i)
        if (w_v_i) mem[w_addr_i] <= w_data_i;

    // Index arithmetic is aw bits wide, so it wraps modulo els_p for free
    for (genvar k = 0; k < issue_width_p; k++) begin : g_rd
        logic [aw-1:0] a;
        assign a = r_addr_i + aw'(k);
        assign r_data_o[k*width_p +: width_p] = mem[a];
    end
endmodule

// File: rtl/bp_be_issue_queue.sv
// bp_be_issue_queue: speculative circular issue buffer with write, speculative-read and commit pointers
module bp_be_issue_queue
  import bp_be_pkg::*;
#(
  parameter int width_p       = 64,
  parameter int els_p         = 8,
  parameter int issue_width_p = 2,
  parameter int deq_width_p   = 2
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic [width_p-1:0]                 enq_data_i,
  input  logic                               enq_v_i,
  output logic                               enq_ready_o,
  output logic [issue_width_p*width_p-1:0]   issue_data_o,
  output logic [issue_width_p-1:0]           issue_v_o,
  input  logic [$clog2(issue_width_p+1)-1:0] issue_yumi_cnt_i,
  input  logic [$clog2(deq_width_p+1)-1:0]   deq_cnt_i,
  input  logic                               roll_i,
  input  logic                               clear_i,
  output logic                               full_o,
  output logic                               empty_o,
  output logic [$clog2(els_p+1)-1:0]         count_o
);
  localparam int pw = `BP_BE_IQ_PTR_WIDTH(els_p);
  localparam int aw = pw - 1;
  localparam int cw = $clog2(els_p+1);

  logic [pw-1:0] wptr, rptr, cptr, wptr_n, rptr_n, cptr_n, cdeq;
  logic [pw-1:0] occ, avail, ahead;
  logic          enq_fire;

  assign occ         = wptr - cptr;
  assign avail       = wptr - rptr;
  assign ahead       = rptr - cptr;
  assign full_o      = occ == pw'(els_p);
  assign empty_o     = occ == '0;
  assign count_o     = cw'(occ);
  assign enq_ready_o = ~full_o & ~clear_i;
  assign enq_fire    = enq_v_i & enq_ready_o;

  for (genvar k = 0; k < issue_width_p; k++) begin : g_v
    assign issue_v_o[k] = avail > pw'(k);
  end

  always_comb begin
    cdeq   = cptr + pw'(deq_cnt_i);
    wptr_n = wptr + pw'(enq_fire);
    cptr_n = clear_i ? wptr : cdeq;
    rptr_n = clear_i ? wptr : roll_i ? cdeq : rptr + pw'(issue_yumi_cnt_i);
  end

  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      wptr <= '0;
      rptr <= '0;
      cptr <= '0;
    end else begin
      wptr <= wptr_n;
      rptr <= rptr_n;
      cptr <= cptr_n;
    end

  bp_be_iq_mem #(
    .width_p      (width_p),
    .els_p        (els_p),
    .issue_width_p(issue_width_p)
  ) u_mem (
    .clk_i   (clk_i),
    .w_v_i   (enq_fire),
    .w_addr_i(wptr[aw-1:0]),
    .w_data_i(enq_data_i),
    .r_addr_i(rptr[aw-1:0]),
    .r_data_o(issue_data_o)
  );

  a_yumi: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    clear_i || roll_i || cnt_ok(int'(issue_yumi_cnt_i), $countones(issue_v_o)));
  a_deq: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    clear_i || cnt_ok(int'(deq_cnt_i), int'(ahead)));
endmodule

// File: tb/tb_bp_be_issue_queue.sv
// tb_bp_be_issue_queue: directed checks of fill/drain, roll, wrap, clear and async reset
module tb_bp_be_issue_queue;
    localparam int w = 16;

    logic         clk = 0;
    logic         reset_n = 0;
    logic [w-1:0] enq_data = '0;
    logic         enq_v = 0;
    logic         enq_ready;
    logic [2*w-1:0] issue_data;
    logic [1:0]   issue_v;
    logic [1:0]   yumi = '0;
    logic [1:0]   deq = '0;
    logic         roll = 0;
    logic         clear = 0;
    logic         full, empty;
    logic [3:0]   count;
    int           n_cmp = 0;
    int           n_err = 0;

    always #5 clk = ~clk;

    bp_be_issue_queue #(.width_p(w), .els_p(8), .issue_width_p(2), .deq_width_p(2)) dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .enq_data_i      (enq_data),
        .enq_v_i         (enq_v),
        .enq_ready_o     (enq_ready),
        .issue_data_o    (issue_data),
        .issue_v_o       (issue_v),
        .issue_yumi_cnt_i(yumi),
        .deq_cnt_i       (deq),
        .roll_i          (roll),
        .clear_i         (clear),
        .full_o          (full),
        .empty_o         (empty),
        .count_o         (count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [w-1:0] d);
        enq_data = d;
        enq_v = 1;
        cyc();
        enq_v = 0;
    endtask

    initial begin
        #2;
        check("rst_ready", enq_ready, 1);
        check("rst_v", issue_v, 0);
        check("rst_full", full, 0);
        check("rst_empty", empty, 1);
        check("rst_count", count, 0);
        cyc();
        reset_n = 1;
        cyc();

        // fill A0..A7
        for (int i = 0; i < 8; i++) enq(16'hA000 + 16'(i));
        check("fill_full", full, 1);
        check("fill_ready", enq_ready, 0);
        check("fill_count", count, 8);
        check("fill_v", issue_v, 2'b11);
        enq(16'hDEAD);
        check("full_drop_count", count, 8);

        // drain in pairs, commit lags issue by one cycle
        for (int j = 0; j < 5; j++) begin
            if (j < 4) begin
                check("drain_ch0", issue_data[0 +: w], 16'hA000 + 16'(2*j));
                check("drain_ch1", issue_data[w +: w], 16'hA001 + 16'(2*j));
            end
            yumi = (j < 4) ? 2'd2 : 2'd0;
            deq  = (j > 0) ? 2'd2 : 2'd0;
            cyc();
            if (j == 1) check("deq_frees", full, 0);
        end
        yumi = 0;
        deq = 0;
        check("drain_empty", empty, 1);
        check("drain_v", issue_v, 0);

        // roll after partial issue
        for (int i = 0; i < 5; i++) enq(16'hB000 + 16'(i));
        yumi = 2; cyc();
        yumi = 2; cyc();
        yumi = 0; deq = 1; cyc();
        check("pre_roll_v", issue_v, 2'b01);
        deq = 0; roll = 1; cyc();
        roll = 0;
        check("roll_ch0", issue_data[0 +: w], 16'hB001);
        check("roll_ch1", issue_data[w +: w], 16'hB002);
        check("roll_count", count, 4);
        check("roll_v", issue_v, 2'b11);

        // roll with same-cycle deq and enqueue; yumi must be ignored
        yumi = 2; cyc();
        yumi = 1; cyc();
        yumi = 2; deq = 2; roll = 1; enq_data = 16'hC000; enq_v = 1;
        cyc();
        yumi = 0; deq = 0; roll = 0; enq_v = 0;
        check("rdq_ch0", issue_data[0 +: w], 16'hB003);
        check("rdq_ch1", issue_data[w +: w], 16'hB004);
        check("rdq_count", count, 3);
        yumi = 2; cyc();
        check("rdq_c0", issue_data[0 +: w], 16'hC000);
        check("rdq_c0_v", issue_v, 2'b01);
        yumi = 1; deq = 2; cyc();
        yumi = 0; deq = 1; cyc();
        deq = 0;
        check("rdq_empty", empty, 1);

        // streaming wrap-around: one enq, one issue, one commit per cycle
        for (int i = 0; i < 20; i++) begin
            if (i > 0) check("wrap_ch0", issue_data[0 +: w], 16'hD000 + 16'(i - 1));
            check("wrap_count", count, (i < 2) ? 4'(i) : 4'd2);
            check("wrap_full", full, 0);
            enq_data = 16'hD000 + 16'(i);
            enq_v = 1;
            yumi = (i > 0) ? 2'd1 : 2'd0;
            deq = (i > 1) ? 2'd1 : 2'd0;
            cyc();
        end
        enq_v = 0;
        check("wrap_last", issue_data[0 +: w], 16'hD013);
        yumi = 1; deq = 1; cyc();
        yumi = 0; deq = 1; cyc();
        deq = 0;
        check("wrap_empty", empty, 1);
        check("wrap_nofull", full, 0);

        // clear with 6 entries, same-cycle enqueue dropped
        for (int i = 0; i < 6; i++) enq(16'hE000 + 16'(i));
        check("clr_count6", count, 6);
        clear = 1; enq_data = 16'hBAD0; enq_v = 1;
        #1;
        check("clr_ready", enq_ready, 0);
        cyc();
        clear = 0; enq_v = 0;
        check("clr_empty", empty, 1);
        check("clr_count", count, 0);
        check("clr_v", issue_v, 0);
        enq(16'hF000);
        check("post_clr_ch0", issue_data[0 +: w], 16'hF000);
        check("post_clr_count", count, 1);
        enq(16'hF001);
        enq(16'hF002);
        enq(16'hF003);
        enq(16'hF004);
        enq(16'hF005);
        enq(16'hF006);
        enq(16'hF007);
        check("pre_rst_full", full, 1);

        // asynchronous reset mid-cycle
        #2;
        reset_n = 0;
        #1;
        check("arst_v", issue_v, 0);
        check("arst_ready", enq_ready, 1);
        check("arst_count", count, 0);
        check("arst_empty", empty, 1);
        cyc();
        reset_n = 1;
        cyc();
        check("arst_hold", empty, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
